// File: rtl/main_memory_interface_burst.sv
// main_memory_interface_burst
// Splits a cache-line read / writeback / flush into sequential memory beats
// of 2^BEAT_OFFSET_BITS words, reassembles read beats into a line and returns
// one MEM_RESP to the cache. Each memory response is only accepted when its
// address matches the beat currently being issued.
module main_memory_interface_burst #(
  parameter int unsigned OFFSET_BITS      = 2,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned ADDRESS_WIDTH    = 12,
  parameter int unsigned MSG_BITS         = 4,
  parameter int unsigned BEAT_OFFSET_BITS = 0
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [MSG_BITS-1:0]                          cache2interface_msg,
  input  logic [ADDRESS_WIDTH-1:0]                     cache2interface_address,
  input  logic [DATA_WIDTH*(1<<OFFSET_BITS)-1:0]       cache2interface_data,
  output logic [MSG_BITS-1:0]                          interface2cache_msg,
  output logic [ADDRESS_WIDTH-1:0]                     interface2cache_address,
  output logic [DATA_WIDTH*(1<<OFFSET_BITS)-1:0]       interface2cache_data,
  input  logic [MSG_BITS-1:0]                          mem2interface_msg,
  input  logic [ADDRESS_WIDTH-1:0]                     mem2interface_address,
  input  logic [DATA_WIDTH*(1<<BEAT_OFFSET_BITS)-1:0]  mem2interface_data,
  output logic [MSG_BITS-1:0]                          interface2mem_msg,
  output logic [ADDRESS_WIDTH-1:0]                     interface2mem_address,
  output logic [DATA_WIDTH*(1<<BEAT_OFFSET_BITS)-1:0]  interface2mem_data
);

  localparam int unsigned WORDS_PER_LINE = 1 << OFFSET_BITS;
  localparam int unsigned WORDS_PER_BEAT = 1 << BEAT_OFFSET_BITS;
  localparam int unsigned LINE_W         = DATA_WIDTH * WORDS_PER_LINE;
  localparam int unsigned BEAT_W         = DATA_WIDTH * WORDS_PER_BEAT;
  localparam int unsigned BEAT_BITS      = OFFSET_BITS - BEAT_OFFSET_BITS;
  localparam int unsigned BEATS          = 1 << BEAT_BITS;
  localparam int unsigned CNT_W          = (BEAT_BITS > 0) ? BEAT_BITS : 1;

  localparam logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0);
  localparam logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] FLUSH    = MSG_BITS'(3);
  localparam logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(4);

  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
    {{(ADDRESS_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [LINE_W-1:0]        r_line, w_line_nxt;
  logic [MSG_BITS-1:0]      r_c_msg, w_c_msg_nxt;
  logic [ADDRESS_WIDTH-1:0] r_c_addr, w_c_addr_nxt;
  logic [LINE_W-1:0]        r_c_data, w_c_data_nxt;
  logic [MSG_BITS-1:0]      r_m_msg, w_m_msg_nxt;
  logic [ADDRESS_WIDTH-1:0] r_m_addr, w_m_addr_nxt;
  logic [BEAT_W-1:0]        r_m_data, w_m_data_nxt;

  logic [ADDRESS_WIDTH-1:0] w_cur_beat_addr;
  logic [ADDRESS_WIDTH-1:0] w_nxt_beat_addr;
  logic                     w_accept;
  logic                     w_last;

  function automatic logic [ADDRESS_WIDTH-1:0] beat_addr(
    input logic [ADDRESS_WIDTH-1:0] base,
    input logic [CNT_W-1:0]         idx
  );
    return (base & LINE_MASK) | (ADDRESS_WIDTH'(idx) << BEAT_OFFSET_BITS);
  endfunction

  assign w_cur_beat_addr = beat_addr(r_addr, r_cnt);
  assign w_nxt_beat_addr = beat_addr(r_addr, w_cnt_nxt);
  assign w_last          = (r_cnt == CNT_W'(BEATS - 1));
  // A beat is only accepted once it has actually been issued (r_m_msg set),
  // so a response left over from an earlier beat can never match.
  assign w_accept = (r_m_msg != NO_REQ) && (mem2interface_msg == MEM_RESP) &&
                    (mem2interface_address == w_cur_beat_addr);

  assign interface2cache_msg     = r_c_msg;
  assign interface2cache_address = r_c_addr;
  assign interface2cache_data    = r_c_data;
  assign interface2mem_msg       = r_m_msg;
  assign interface2mem_address   = r_m_addr;
  assign interface2mem_data      = r_m_data;

  // State, counter, line buffer and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_line   <= '0;
      r_c_msg  <= NO_REQ;
      r_c_addr <= '0;
      r_c_data <= '0;
      r_m_msg  <= NO_REQ;
      r_m_addr <= '0;
      r_m_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_line   <= w_line_nxt;
      r_c_msg  <= w_c_msg_nxt;
      r_c_addr <= w_c_addr_nxt;
      r_c_data <= w_c_data_nxt;
      r_m_msg  <= w_m_msg_nxt;
      r_m_addr <= w_m_addr_nxt;
      r_m_data <= w_m_data_nxt;
    end
  end

  // Next-state, beat sequencing and next output values
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_addr;
    w_line_nxt   = r_line;
    w_c_msg_nxt  = NO_REQ;
    w_c_addr_nxt = r_c_addr;
    w_c_data_nxt = r_c_data;
    w_m_msg_nxt  = NO_REQ;
    w_m_addr_nxt = '0;
    w_m_data_nxt = '0;

    case (r_state)
      S_IDLE: begin
        if (cache2interface_msg == R_REQ) begin
          w_addr_nxt  = cache2interface_address;
          w_cnt_nxt   = '0;
          w_state_nxt = S_READ;
        end else if ((cache2interface_msg == WB_REQ) ||
                     (cache2interface_msg == FLUSH)) begin
          w_addr_nxt  = cache2interface_address;
          w_line_nxt  = cache2interface_data;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WRITE;
        end
      end

      S_READ: begin
        if (w_accept) begin
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
              w_line_nxt[b*BEAT_W +: BEAT_W] = mem2interface_data;
            end
          end
          if (w_last) begin
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        if (w_state_nxt == S_READ) begin
          w_m_msg_nxt  = R_REQ;
          w_m_addr_nxt = w_nxt_beat_addr;
        end
      end

      S_WRITE: begin
        if (w_accept) begin
          if (w_last) begin
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        if (w_state_nxt == S_WRITE) begin
          w_m_msg_nxt  = WB_REQ;
          w_m_addr_nxt = w_nxt_beat_addr;
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (w_cnt_nxt == CNT_W'(b)) begin
              w_m_data_nxt = r_line[b*BEAT_W +: BEAT_W];
            end
          end
        end
      end

      S_RESP: begin
        w_c_msg_nxt  = MEM_RESP;
        w_c_addr_nxt = r_addr;
        w_c_data_nxt = r_line;
        // Leave only once the cache has actually seen MEM_RESP.
        if ((r_c_msg == MEM_RESP) && (cache2interface_msg == NO_REQ)) begin
          w_state_nxt = S_IDLE;
          w_c_msg_nxt = NO_REQ;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
